control_sequencer: RTL



---
 rtl/control_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch plus immediate/memory instruction classes.
// Optional trap on unknown opcodes is enabled by defining ILLEGAL_OP_TRAP_EN.
module control_sequencer (
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  Operator,
  output logic        halted,
  output logic        illegal
);

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [OP_W-1:0] ALU_AND = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OR  = 5'b00110;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01010;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01100;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] opcode;
  logic            is_mem;
  logic            is_alu_imm;
  logic            unused_ir;

  assign opcode     = IR[31:27];
  assign is_mem     = (opcode == OP_LD) || (opcode == OP_ST);
  assign is_alu_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign unused_ir  = ^IR[26:0];

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (!clear) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state strobe decode
  always_comb begin
    state_d  = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d = illegal_q;
`endif
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    Cout     = 1'b0;
    Operator = 5'b00000;
    halted   = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = mem_ready ? S_T2 : S_T1W;
      end
      // PC already loaded in T1, so only the memory read is held here
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        case (opcode)
          OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: state_d = S_T3;
          OP_NOP:  state_d = S_T0;
          OP_HALT: state_d = S_HALT;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_T0;
`endif
          end
        endcase
      end
      S_T3: begin
        Grb   = 1'b1;
        Yin   = 1'b1;
        Rout  = is_alu_imm;
        BAout = !is_alu_imm;
        state_d = S_T4;
      end
      S_T4: begin
        Cout = 1'b1;
        Zin  = 1'b1;
        if (opcode == OP_ANDI)     Operator = ALU_AND;
        else if (opcode == OP_ORI) Operator = ALU_OR;
        else                       Operator = ALU_ADD;
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        MARin   = is_mem;
        Gra     = !is_mem;
        Rin     = !is_mem;
        state_d = is_mem ? S_T6 : S_T0;
      end
      S_T6: begin
        MDRin = 1'b1;
        if (opcode == OP_LD) begin
          Read = 1'b1;
          if (mem_ready) state_d = S_T7;
        end else begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          state_d = S_T7;
        end
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          MDRout  = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = S_T0;
        end else begin
          Write = 1'b1;
          if (mem_ready) state_d = S_T0;
        end
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
